// File: rtl/serial_frame_sequencer_if.sv
// Stream interface for serial_frame_sequencer: the word-in stream (s_*) and
// the captured-word-out stream (m_*). The master side is the host that feeds
// words and drains results; the slave side is the sequencer itself.
interface serial_frame_sequencer_if #(
    parameter int W = 8
);
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_err;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_err
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_err
    );
endinterface

// File: rtl/serial_frame_sequencer.sv
// serial_frame_sequencer: takes one parallel word at a time, shifts it MSB-first
// into the bit-serial datapath with dp_en held high, captures the datapath's
// serial response LAT clocks later and returns the reassembled word.
// Optional feature macro: SEQ_PARITY_EN appends an even-parity bit to each
// frame and reports a parity mismatch on m_err (otherwise m_err is tied 0).
//
// state | meaning
// IDLE  | waiting for a word, s_ready high
// SHIFT | dp_en high, one frame bit per clock onto dp_d
// DRAIN | datapath pipeline still delivering response bits
// DONE  | captured word presented on m_valid/m_data until taken
module serial_frame_sequencer #(
    parameter int W     = 8,
    parameter int LAT   = 1,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_frame_sequencer_if.slave bus,
    output logic                   dp_en,
    output logic                   dp_d,
    input  logic                   dp_q,
    output logic                   busy,
    output logic [CNT_W-1:0]       frame_cnt
);

`ifdef SEQ_PARITY_EN
    localparam int N = W + 1;
`else
    localparam int N = W;
`endif
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

    state_t        state;
    logic [N-1:0]  shift_reg;
    logic [N-1:0]  rx;
    logic [N-1:0]  rx_next;
    logic [N-1:0]  load_val;
    logic [CW-1:0] tx_cnt;
    logic [CW-1:0] rx_cnt;
    logic          en_dly;
    logic          cap_done;
    logic          tx_last;
    logic          enter_done;
    logic          m_valid_r;
    logic [W-1:0]  m_data_r;
    logic [W-1:0]  cap_data;

    assign bus.s_ready = (state == IDLE);
    assign bus.m_valid = m_valid_r;
    assign bus.m_data  = m_data_r;

`ifdef SEQ_PARITY_EN
    logic m_err_r;
    logic cap_err;
    assign load_val    = {bus.s_data, ^bus.s_data};
    // Last captured bit is the parity bit; compare it against the data bits.
    assign cap_err     = (^rx_next[N-1:1]) ^ rx_next[0];
    assign bus.m_err   = m_err_r;
`else
    assign load_val    = bus.s_data;
    assign bus.m_err   = 1'b0;
`endif

    assign rx_next    = {rx[N-2:0], dp_q};
    assign cap_data   = rx_next[N-1 -: W];
    // cap_done marks the edge that takes in the final response bit.
    assign cap_done   = en_dly && (rx_cnt == CW'(N - 1));
    assign tx_last    = (tx_cnt == CW'(N - 1));
    // With LAT=0 the final capture lands on the last SHIFT edge, so DRAIN is skipped.
    assign enter_done = cap_done && ((state == DRAIN) || ((state == SHIFT) && tx_last));

    generate
        if (LAT == 0) begin : g_no_dly
            assign en_dly = dp_en;
        end else begin : g_dly
            logic [LAT-1:0] en_pipe;
            // Delay dp_en by LAT clocks to line up with valid dp_q.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    en_pipe <= '0;
                end else begin
                    en_pipe <= (en_pipe << 1) | LAT'(dp_en);
                end
            end
            assign en_dly = en_pipe[LAT-1];
        end
    endgenerate

    // Frame sequencing FSM with registered outputs and response capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            rx        <= '0;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
            dp_en     <= 1'b0;
            dp_d      <= 1'b0;
            busy      <= 1'b0;
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
            frame_cnt <= '0;
`ifdef SEQ_PARITY_EN
            m_err_r   <= 1'b0;
`endif
        end else begin
            if (en_dly) begin
                rx     <= rx_next;
                rx_cnt <= rx_cnt + CW'(1);
            end

            case (state)
                IDLE: begin
                    if (bus.s_valid) begin
                        shift_reg <= load_val;
                        dp_d      <= load_val[N-1];
                        dp_en     <= 1'b1;
                        tx_cnt    <= '0;
                        rx_cnt    <= '0;
                        rx        <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tx_last) begin
                        dp_en <= 1'b0;
                        dp_d  <= 1'b0;
                        state <= cap_done ? DONE : DRAIN;
                    end else begin
                        dp_d      <= shift_reg[N-2];
                        shift_reg <= shift_reg << 1;
                        tx_cnt    <= tx_cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (cap_done) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.m_ready) begin
                        m_valid_r <= 1'b0;
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (enter_done) begin
                m_valid_r <= 1'b1;
                m_data_r  <= cap_data;
`ifdef SEQ_PARITY_EN
                m_err_r   <= cap_err;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_sequencer.sv
// Bench for serial_frame_sequencer. Two instances share one stimulus stream:
// A: W=8, LAT=1, CNT_W=16 behind a 1-clock register datapath.
// B: W=8, LAT=0, CNT_W=2 behind a combinational inverting datapath.
// A timeline model (accept time + frame word) predicts every output each cycle.
module tb_serial_frame_sequencer;

`ifdef SEQ_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int N = 8 + PAR;

    logic       clk;
    logic       rst;
    logic       s_valid;
    logic [7:0] s_data;
    logic       m_ready;
    logic       flip_req;
    logic       flip_a;

    serial_frame_sequencer_if #(.W(8)) bus_a ();
    serial_frame_sequencer_if #(.W(8)) bus_b ();

    assign bus_a.s_valid = s_valid;
    assign bus_a.s_data  = s_data;
    assign bus_a.m_ready = m_ready;
    assign bus_b.s_valid = s_valid;
    assign bus_b.s_data  = s_data;
    assign bus_b.m_ready = m_ready;

    logic        dp_en_a, dp_d_a, dp_q_a, busy_a;
    logic        dp_en_b, dp_d_b, dp_q_b, busy_b;
    logic [15:0] fc_a;
    logic [1:0]  fc_b;

    serial_frame_sequencer #(.W(8), .LAT(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave),
        .dp_en(dp_en_a), .dp_d(dp_d_a), .dp_q(dp_q_a),
        .busy(busy_a), .frame_cnt(fc_a)
    );

    serial_frame_sequencer #(.W(8), .LAT(0), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave),
        .dp_en(dp_en_b), .dp_d(dp_d_b), .dp_q(dp_q_b),
        .busy(busy_b), .frame_cnt(fc_b)
    );

    // Datapath A: one-clock register; optionally corrupts the last frame bit.
    int dp_idx;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_q_a <= 1'b0;
            dp_idx <= 0;
        end else if (dp_en_a) begin
            dp_q_a <= dp_d_a ^ (flip_a && (dp_idx == N - 1));
            dp_idx <= dp_idx + 1;
        end else begin
            dp_q_a <= dp_d_a;
            dp_idx <= 0;
        end
    end

    // Datapath B: combinational inverter.
    assign dp_q_b = ~dp_d_b;

    logic       o_sr[2], o_bz[2], o_en[2], o_dd[2], o_mv[2], o_me[2];
    logic [7:0] o_md[2];
    logic [15:0] o_fc[2];
    assign o_sr[0] = bus_a.s_ready;  assign o_sr[1] = bus_b.s_ready;
    assign o_bz[0] = busy_a;         assign o_bz[1] = busy_b;
    assign o_en[0] = dp_en_a;        assign o_en[1] = dp_en_b;
    assign o_dd[0] = dp_d_a;         assign o_dd[1] = dp_d_b;
    assign o_mv[0] = bus_a.m_valid;  assign o_mv[1] = bus_b.m_valid;
    assign o_me[0] = bus_a.m_err;    assign o_me[1] = bus_b.m_err;
    assign o_md[0] = bus_a.m_data;   assign o_md[1] = bus_b.m_data;
    assign o_fc[0] = fc_a;           assign o_fc[1] = {14'b0, fc_b};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    // Bit j (0 = first sent) of the transmitted frame.
    function automatic logic tx_bit(input logic [7:0] w, input int j);
        logic [8:0] sq;
        sq = {w, ^w};
        return sq[8 - j];
    endfunction

    // Bits the sequencer should capture, first-captured bit at position 8.
    function automatic logic [8:0] cap_bits(input int i, input logic [7:0] w, input bit f);
        logic [8:0] cb;
        logic b;
        cb = '0;
        for (int j = 0; j < N; j++) begin
            b = tx_bit(w, j);
            if (i == 0) b = b ^ (f && (j == N - 1));
            else        b = ~b;
            cb[8 - j] = b;
        end
        return cb;
    endfunction

    // Timeline model and per-cycle compare.
    bit         inf[2];
    int         ta[2];
    logic [7:0] wd[2];
    bit         fl[2];
    int         cnt[2];
    int         k;

    initial begin
        k = 0;
        flip_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            inf[i] = 0; ta[i] = 0; wd[i] = '0; fl[i] = 0; cnt[i] = 0;
        end
        forever begin
            @(posedge clk);
            k++;
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    inf[i] = 0;
                    cnt[i] = 0;
                end else if (inf[i] && (k - 1 - ta[i]) >= N + lat_of(i) && m_ready) begin
                    inf[i] = 0;
                    cnt[i]++;
                end else if (!inf[i] && s_valid) begin
                    inf[i] = 1;
                    ta[i]  = k;
                    wd[i]  = s_data;
                    fl[i]  = (i == 0) ? flip_req : 1'b0;
                    if (i == 0) flip_a = flip_req;
                end
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                int d;
                logic e_en, e_dd, e_mv, e_err;
                logic [8:0] cb;
                string nm;
                nm   = (i == 0) ? "a" : "b";
                d    = k - ta[i];
                e_en = inf[i] && (d < N);
                e_dd = e_en ? tx_bit(wd[i], d) : 1'b0;
                e_mv = inf[i] && (d >= N + lat_of(i));
                cb   = cap_bits(i, wd[i], fl[i]);
                e_err = (PAR != 0) ? ((^cb[8:1]) != cb[0]) : 1'b0;
                chk({nm, ".s_ready"}, o_sr[i], !inf[i]);
                chk({nm, ".busy"}, o_bz[i], inf[i]);
                chk({nm, ".dp_en"}, o_en[i], e_en);
                chk({nm, ".dp_d"}, o_dd[i], e_dd);
                chk({nm, ".m_valid"}, o_mv[i], e_mv);
                chk({nm, ".frame_cnt"}, o_fc[i], (i == 0) ? (cnt[i] & 16'hFFFF) : (cnt[i] & 3));
                if (e_mv) begin
                    chk({nm, ".m_data"}, o_md[i], cb[8:1]);
                    chk({nm, ".m_err"}, o_me[i], e_err);
                end
            end
        end
    end

    int         meas_lat[2];
    int         meas_en[2];
    logic [8:0] meas_bits[2];
    logic [7:0] meas_dat[2];
    logic       meas_er[2];

    task automatic sample(input int e);
        for (int i = 0; i < 2; i++) begin
            if (o_en[i]) begin
                meas_bits[i] = {meas_bits[i][7:0], o_dd[i]};
                meas_en[i]++;
            end
            if (o_mv[i] && meas_lat[i] < 0) begin
                meas_lat[i] = e;
                meas_dat[i] = o_md[i];
                meas_er[i]  = o_me[i];
            end
        end
    endtask

    // Send one word to both idle instances and record latency and bit stream.
    task automatic send_measure(input logic [7:0] w);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = w;
        m_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            meas_lat[i] = -1; meas_en[i] = 0; meas_bits[i] = '0;
            meas_dat[i] = '0; meas_er[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        sample(0);
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            sample(e);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(o_sr[0] && o_sr[1]) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("idle_wait", t < 100, 1'b1);
    endtask

    initial begin
        int         exp_seq[5];
        logic [1:0] got[5];
        int         t;
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b1;
        flip_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.s_ready", o_sr[0], 1'b1);
        chk("rst.m_valid", o_mv[0], 1'b0);
        chk("rst.dp_en", o_en[0], 1'b0);
        chk("rst.frame_cnt", o_fc[0], 16'd0);

        // 0xA5 through both datapaths
        send_measure(8'hA5);
        chk("a5.a_bits", meas_bits[0], (PAR != 0) ? 9'h14A : 9'h0A5);
        chk("a5.a_en_cycles", meas_en[0], N);
        chk("a5.a_latency", meas_lat[0], N + 1);
        chk("a5.a_data", meas_dat[0], 8'hA5);
        chk("a5.b_latency", meas_lat[1], N);
        chk("a5.b_data", meas_dat[1], 8'h5A);
        @(negedge clk);
        chk("a5.a_frame_cnt", o_fc[0], 16'd1);

        // 0x3C: B skips DRAIN and returns the inverted word
        send_measure(8'h3C);
        chk("3c.b_latency", meas_lat[1], N);
        chk("3c.b_data", meas_dat[1], 8'hC3);
        chk("3c.a_data", meas_dat[0], 8'h3C);
        @(negedge clk);
        chk("3c.b_frame_cnt", o_fc[1], 16'd2);

        // Back-pressure with a second word waiting
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h5A;
        @(negedge clk);
        s_data  = 8'hFF;
        repeat (20) @(negedge clk);
        chk("bp.a_m_valid", o_mv[0], 1'b1);
        chk("bp.a_m_data", o_md[0], 8'h5A);
        chk("bp.a_s_ready", o_sr[0], 1'b0);
        chk("bp.b_m_data", o_md[1], 8'hA5);
        m_ready = 1'b1;
        @(negedge clk);
        chk("bp.a_ready_after_take", o_sr[0], 1'b1);
        @(negedge clk);
        chk("bp.a_second_accepted", o_bz[0], 1'b1);
        s_valid = 1'b0;
        wait_idle();

        // Reset in the fourth SHIFT cycle
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'h99;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid.a_dp_en_before", o_en[0], 1'b1);
        rst = 1'b1;
        #1;
        chk("rstmid.a_dp_en", o_en[0], 1'b0);
        chk("rstmid.b_dp_en", o_en[1], 1'b0);
        chk("rstmid.a_m_valid", o_mv[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        send_measure(8'h81);
        chk("81.a_data", meas_dat[0], 8'h81);
        chk("81.b_data", meas_dat[1], 8'h7E);
        @(negedge clk);
        chk("81.a_frame_cnt", o_fc[0], 16'd1);
        chk("81.b_frame_cnt", o_fc[1], 16'd1);

        // Frame counter wrap on B (CNT_W=2), back-to-back frames
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_seq = '{1, 2, 3, 0, 1};
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int f = 0; f < 5; f++) begin
            t = 0;
            while (!o_mv[1] && t < 50) begin
                @(negedge clk);
                s_data = 8'($urandom);
                t++;
            end
            chk("wrap.wait", t < 50, 1'b1);
            @(negedge clk);
            got[f] = fc_b;
        end
        s_valid = 1'b0;
        for (int f = 0; f < 5; f++) chk($sformatf("wrap.frame_cnt[%0d]", f), got[f], exp_seq[f]);
        wait_idle();

        // Random traffic against the model
        repeat (600) begin
            @(negedge clk);
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 8'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            if (PAR != 0) flip_req = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        s_valid  = 1'b0;
        m_ready  = 1'b1;
        flip_req = 1'b0;
        wait_idle();

`ifdef SEQ_PARITY_EN
        // Parity bit on the wire and mismatch detection
        send_measure(8'h07);
        chk("par.a_bits", meas_bits[0], 9'h00F);
        chk("par.a_ninth_bit", meas_bits[0][0], 1'b1);
        chk("par.a_err_clean", meas_er[0], 1'b0);
        chk("par.b_err_inverted", meas_er[1], 1'b1);
        flip_req = 1'b1;
        send_measure(8'h07);
        chk("par.a_err_flipped", meas_er[0], 1'b1);
        chk("par.a_data_flipped", meas_dat[0], 8'h07);
        flip_req = 1'b0;
        wait_idle();
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_frame_sequencer.md
Name: serial_frame_sequencer

Overview:
Controller that drives the bit-serial datapath (the `top` serial core: en / i_d in, o_q out). It accepts parallel words over a valid/ready stream and shifts each word MSB-first into the datapath while holding en high. It captures the datapath's serial response after a fixed pipeline latency and returns the reassembled word over a second valid/ready stream. One frame is in flight at a time.

Parameters:
W, 8, frame width in bits (2..32)
LAT, 1, datapath latency in clocks from dp_en/dp_d sample edge to valid dp_q (0..7; 0 = combinational datapath)
CNT_W, 16, width of completed-frame counter

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous active-high reset
s_valid  in  1  input word valid
s_ready  out  1  sequencer can accept a word
s_data  in  W  word to serialise
m_valid  out  1  captured word valid
m_ready  in  1  downstream accepts captured word
m_data  out  W  captured word, first-received bit in MSB
m_err  out  1  parity mismatch flag, qualified by m_valid
dp_en  out  1  datapath enable (drives en)
dp_d  out  1  serial data to datapath (drives i_d)
dp_q  in  1  serial data from datapath (o_q)
busy  out  1  high in any state except IDLE
frame_cnt  out  CNT_W  count of frames completed on m handshake

Behaviour:
- Reset (async, active-high): state=IDLE; s_ready=1; m_valid=0; m_data=0; m_err=0; dp_en=0; dp_d=0; busy=0; frame_cnt=0; shift, capture and en-delay registers cleared. Reset mid-frame aborts the frame with no output. dp_en drops immediately on rst assertion.
- All outputs are registered except s_ready, which is (state==IDLE).
- States: IDLE, SHIFT, DRAIN, DONE.
- IDLE: on s_valid&&s_ready, load shift reg with s_data, clear tx/rx counters, go to SHIFT.
- SHIFT: dp_en=1, dp_d=shift MSB, shift left each clock. Lasts exactly N cycles (N=W, or W+1 with the optional feature). Then go to DRAIN, or directly to DONE when LAT=0 and capture is complete.
- Capture: en_dly is dp_en delayed LAT clocks (en_dly=dp_en when LAT=0). On each edge with en_dly=1: rx <= {rx[W-2:0], dp_q} and increment rx count.
- DRAIN: dp_en=0, dp_d=0. Wait until rx count==N, then go to DONE.
- DONE: m_valid=1, m_data=rx. Hold stable while m_ready=0. On m_valid&&m_ready: frame_cnt+1 (wraps 2^CNT_W-1 -> 0) and return to IDLE.
- Timing: m_valid rises W+LAT edges after the accept edge (N+LAT with the feature). Minimum frame-to-frame spacing is N+LAT+2 clocks.
- s_valid outside IDLE is ignored and s_data is not sampled. An accept cannot coincide with the m handshake, because s_ready=0 in DONE.
- dp_en is never high outside SHIFT. dp_d=0 whenever dp_en=0.

Optional Feature:
Macro SEQ_PARITY_EN.
- Defined: N=W+1. After the W data bits, SHIFT drives one extra bit equal to the even parity (XOR) of s_data. Capture takes W+1 bits: the first W go to m_data, and the last is compared with the XOR of the captured W bits. m_err=1 in DONE on mismatch, else 0.
- Undefined: N=W, no parity bit, and m_err is tied 0.

Test Plan:
- W=8, LAT=1, datapath modelled as a 1-clock register, m_ready=1; send 0xA5 -> dp_d sequence 1,0,1,0,0,1,0,1 with dp_en high exactly 8 cycles; m_valid rises 9 edges after accept with m_data=0xA5; frame_cnt=1.
- LAT=0, combinational inverting datapath; send 0x3C -> no DRAIN cycle; m_data=0xC3; m_valid rises 8 edges after accept.
- Back-pressure: send 0x5A with m_ready=0 for 20 cycles -> m_valid/m_data=0x5A held stable, s_ready=0 throughout; a second s_valid with 0xFF is not accepted until 1 cycle after m_ready=1.
- Reset mid-SHIFT: assert rst on the 4th SHIFT cycle -> dp_en=0 immediately, no m_valid; send 0x81 after release -> m_data=0x81, frame_cnt=1.
- CNT_W=2: complete 5 back-to-back frames -> frame_cnt sequence 1,2,3,0,1.
- SEQ_PARITY_EN, LAT=1: send 0x07 -> 9th dp_d bit=1, m_err=0; datapath model flips the parity bit -> m_err=1 with m_data=0x07.
